// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, IF/ID pipeline register, sticky
// redirect-alignment flag and a saturating count of accepted instructions.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic [31:0] ImemInstruction,
    output logic [31:0] ImemAddress,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        AlignError,
    output logic [31:0] FetchCount
);

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    logic        align_q;
    logic [31:0] count_q;

    // Wraps naturally modulo 2^32.
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            align_q    <= 1'b0;
            count_q    <= '0;
        end else if (Redirect) begin
            // Redirect wins over Stall; the fetched word is squashed into a bubble.
            pc_q    <= {RedirectPC[31:2], 2'b00};
            instr_q <= '0;
            valid_q <= 1'b0;
            if (RedirectPC[1:0] != 2'b00) begin
                align_q <= 1'b1;
            end
        end else if (!Stall) begin
            pc_q       <= pc_plus4;
            instr_q    <= ImemInstruction;
            pc_plus4_q <= pc_plus4;
            valid_q    <= 1'b1;
            if (count_q != '1) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign PC                = pc_q;
    assign ImemAddress       = pc_q;
    assign IF_ID_Instruction = instr_q;
    assign IF_ID_PCPlus4     = pc_plus4_q;
    assign IF_ID_Valid       = valid_q;
    assign AlignError        = align_q;
    assign FetchCount        = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit; instruction memory
// returns word_index*3 for every address.
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic [31:0] ImemInstruction;
    logic [31:0] ImemAddress;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instruction;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        AlignError;
    logic [31:0] FetchCount;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .Redirect         (Redirect),
        .RedirectPC       (RedirectPC),
        .ImemInstruction  (ImemInstruction),
        .ImemAddress      (ImemAddress),
        .PC               (PC),
        .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4    (IF_ID_PCPlus4),
        .IF_ID_Valid      (IF_ID_Valid),
        .AlignError       (AlignError),
        .FetchCount       (FetchCount)
    );

    assign ImemInstruction = (ImemAddress >> 2) * 32'd3;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0;
        #3;
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", PC, 32'h0); end
        checks++; if (IF_ID_Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", IF_ID_Instruction); end
        checks++; if (IF_ID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcplus4 got %h want 0", IF_ID_PCPlus4); end
        checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", IF_ID_Valid); end
        checks++; if (AlignError !== 1'b0) begin errors++; $display("FAIL reset_align got %b want 0", AlignError); end
        checks++; if (FetchCount !== 32'h0) begin errors++; $display("FAIL reset_count got %0d want 0", FetchCount); end
        tick();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_hold_pc got %h want 0", PC); end
        checks++; if (ImemAddress !== PC) begin errors++; $display("FAIL imem_addr got %h want %h", ImemAddress, PC); end
    endtask

    task automatic test_sequential();
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (IF_ID_Instruction !== 32'(i * 3)) begin errors++; $display("FAIL seq_instr[%0d] got %0d want %0d", i, IF_ID_Instruction, i * 3); end
            checks++; if (IF_ID_PCPlus4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL seq_pcplus4[%0d] got %0d want %0d", i, IF_ID_PCPlus4, 4 * (i + 1)); end
            checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, IF_ID_Valid); end
        end
        checks++; if (PC !== 32'd16) begin errors++; $display("FAIL seq_pc got %0d want 16", PC); end
        checks++; if (FetchCount !== 32'd4) begin errors++; $display("FAIL seq_count got %0d want 4", FetchCount); end
        checks++; if (ImemAddress !== 32'd16) begin errors++; $display("FAIL seq_imem_addr got %0d want 16", ImemAddress); end
    endtask

    task automatic test_stall();
        Reset = 1'b0; #2; Reset = 1'b1;
        tick(); tick();
        checks++; if (PC !== 32'd8) begin errors++; $display("FAIL stall_pre_pc got %0d want 8", PC); end
        Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (PC !== 32'd8) begin errors++; $display("FAIL stall_pc[%0d] got %0d want 8", i, PC); end
            checks++; if (IF_ID_Instruction !== 32'd3) begin errors++; $display("FAIL stall_instr[%0d] got %0d want 3", i, IF_ID_Instruction); end
            checks++; if (IF_ID_PCPlus4 !== 32'd8) begin errors++; $display("FAIL stall_pcplus4[%0d] got %0d want 8", i, IF_ID_PCPlus4); end
            checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, IF_ID_Valid); end
            checks++; if (FetchCount !== 32'd2) begin errors++; $display("FAIL stall_count[%0d] got %0d want 2", i, FetchCount); end
        end
        Stall = 1'b0;
        tick();
        checks++; if (PC !== 32'd12) begin errors++; $display("FAIL resume_pc got %0d want 12", PC); end
        checks++; if (IF_ID_Instruction !== 32'd6) begin errors++; $display("FAIL resume_instr got %0d want 6", IF_ID_Instruction); end
        checks++; if (FetchCount !== 32'd3) begin errors++; $display("FAIL resume_count got %0d want 3", FetchCount); end
    endtask

    task automatic test_redirect_stall();
        Stall = 1'b1; Redirect = 1'b1; RedirectPC = 32'h40;
        tick();
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL redir_pc got %h want 40", PC); end
        checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", IF_ID_Valid); end
        checks++; if (IF_ID_Instruction !== 32'h0) begin errors++; $display("FAIL redir_instr got %h want 0", IF_ID_Instruction); end
        checks++; if (IF_ID_PCPlus4 !== 32'd12) begin errors++; $display("FAIL redir_pcplus4 got %0d want 12", IF_ID_PCPlus4); end
        checks++; if (FetchCount !== 32'd3) begin errors++; $display("FAIL redir_count got %0d want 3", FetchCount); end
        Stall = 1'b0; Redirect = 1'b0;
        tick();
        checks++; if (IF_ID_Instruction !== 32'd48) begin errors++; $display("FAIL redir_next_instr got %0d want 48", IF_ID_Instruction); end
        checks++; if (IF_ID_PCPlus4 !== 32'h44) begin errors++; $display("FAIL redir_next_pcplus4 got %h want 44", IF_ID_PCPlus4); end
        checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL redir_next_valid got %b want 1", IF_ID_Valid); end
        checks++; if (FetchCount !== 32'd4) begin errors++; $display("FAIL redir_next_count got %0d want 4", FetchCount); end
    endtask

    task automatic test_redirect_same_pc();
        Redirect = 1'b1; RedirectPC = 32'h44;
        tick();
        checks++; if (PC !== 32'h44) begin errors++; $display("FAIL same_pc got %h want 44", PC); end
        checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL same_valid got %b want 0", IF_ID_Valid); end
        checks++; if (FetchCount !== 32'd4) begin errors++; $display("FAIL same_count got %0d want 4", FetchCount); end
        Redirect = 1'b0;
        tick();
        checks++; if (IF_ID_Instruction !== 32'd51) begin errors++; $display("FAIL same_next_instr got %0d want 51", IF_ID_Instruction); end
        checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL same_next_valid got %b want 1", IF_ID_Valid); end
    endtask

    task automatic test_misaligned();
        checks++; if (AlignError !== 1'b0) begin errors++; $display("FAIL align_pre got %b want 0", AlignError); end
        Redirect = 1'b1; RedirectPC = 32'h23;
        tick();
        checks++; if (PC !== 32'h20) begin errors++; $display("FAIL align_pc got %h want 20", PC); end
        checks++; if (AlignError !== 1'b1) begin errors++; $display("FAIL align_set got %b want 1", AlignError); end
        checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL align_valid got %b want 0", IF_ID_Valid); end
        Redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (AlignError !== 1'b1) begin errors++; $display("FAIL align_sticky[%0d] got %b want 1", i, AlignError); end
        end
        checks++; if (PC !== 32'h48) begin errors++; $display("FAIL align_end_pc got %h want 48", PC); end
        checks++; if (FetchCount !== 32'd15) begin errors++; $display("FAIL align_end_count got %0d want 15", FetchCount); end
    endtask

    task automatic test_wrap();
        Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
        tick();
        checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_redir_pc got %h want fffffffc", PC); end
        Redirect = 1'b0;
        tick();
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc0 got %h want 0", PC); end
        checks++; if (IF_ID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 got %h want 0", IF_ID_PCPlus4); end
        checks++; if (IF_ID_Instruction !== 32'hBFFF_FFFD) begin errors++; $display("FAIL wrap_instr got %h want bffffffd", IF_ID_Instruction); end
        tick();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL wrap_pc4 got %h want 4", PC); end
        checks++; if (IF_ID_PCPlus4 !== 32'h4) begin errors++; $display("FAIL wrap_pcplus4_2 got %h want 4", IF_ID_PCPlus4); end
        checks++; if (AlignError !== 1'b1) begin errors++; $display("FAIL wrap_align got %b want 1", AlignError); end
    endtask

    task automatic test_async_reset();
        Redirect = 1'b1; RedirectPC = 32'h30;
        tick();
        Redirect = 1'b0;
        checks++; if (PC !== 32'h30) begin errors++; $display("FAIL areset_pre_pc got %h want 30", PC); end
        #2;
        Reset = 1'b0;
        #1;
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL areset_pc got %h want 0", PC); end
        checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", IF_ID_Valid); end
        checks++; if (FetchCount !== 32'h0) begin errors++; $display("FAIL areset_count got %0d want 0", FetchCount); end
        checks++; if (AlignError !== 1'b0) begin errors++; $display("FAIL areset_align got %b want 0", AlignError); end
        checks++; if (IF_ID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL areset_pcplus4 got %h want 0", IF_ID_PCPlus4); end
        #2;
        Reset = 1'b1;
        tick();
        checks++; if (PC !== 32'h4) begin errors++; $display("FAIL post_reset_pc got %h want 4", PC); end
        checks++; if (FetchCount !== 32'd1) begin errors++; $display("FAIL post_reset_count got %0d want 1", FetchCount); end
        checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL post_reset_valid got %b want 1", IF_ID_Valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_redirect_same_pc();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
